// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory that answers load/store requests
// from the core after a fixed LATENCY. Requests are strictly serialized:
// one request is in flight at a time, and the next is taken only after the
// response handshake has completed.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_func,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DATA_W = 32;
  localparam int AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // load_store_func_code encoding shared with the core
  localparam logic [3:0] FUNC_NOP = 4'd0;
  localparam logic [3:0] FUNC_LW  = 4'd1;
  localparam logic [3:0] FUNC_LH  = 4'd2;
  localparam logic [3:0] FUNC_LB  = 4'd3;
  localparam logic [3:0] FUNC_LHU = 4'd4;
  localparam logic [3:0] FUNC_LBU = 4'd5;
  localparam logic [3:0] FUNC_SW  = 4'd6;
  localparam logic [3:0] FUNC_SH  = 4'd7;
  localparam logic [3:0] FUNC_SB  = 4'd8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic [29:0]       word_idx;
  logic              in_range;
  logic [AW-1:0]     mem_idx;
  logic [DATA_W-1:0] rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic              is_load;
  logic              is_store;
  logic              misalign;
  logic [3:0]        byte_en;
  logic [DATA_W-1:0] wr_lanes;
  logic [DATA_W-1:0] load_data;
  logic              acc_err_p0;
  logic [DATA_W-1:0] acc_rdata_p0;
  logic              wr_en_p0;

  // Sign- or zero-extend a selected byte to a full word
  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sign_ext);
    logic signed [7:0]        b_s;
    logic signed [DATA_W-1:0] w_s;
    b_s = signed'(b);
    w_s = b_s;
    return sign_ext ? unsigned'(w_s) : {24'b0, b};
  endfunction

  // Sign- or zero-extend a selected halfword to a full word
  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sign_ext);
    logic signed [15:0]       h_s;
    logic signed [DATA_W-1:0] w_s;
    h_s = signed'(h);
    w_s = h_s;
    return sign_ext ? unsigned'(w_s) : {16'b0, h};
  endfunction

  assign word_idx = req_addr[31:2];
  assign in_range = {2'b00, word_idx} < 32'(DEPTH_WORDS);
  assign mem_idx  = word_idx[AW-1:0];
  assign rd_word  = mem[mem_idx];
  assign byte_sel = rd_word[{req_addr[1:0], 3'b000} +: 8];
  assign half_sel = rd_word[{req_addr[1], 4'b0000} +: 16];

  // Decode the incoming request: alignment, lane enables and load result
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    misalign  = 1'b0;
    byte_en   = 4'b0000;
    wr_lanes  = '0;
    load_data = '0;
    case (req_func)
      FUNC_LW: begin
        is_load   = 1'b1;
        misalign  = |req_addr[1:0];
        load_data = rd_word;
      end
      FUNC_LH: begin
        is_load   = 1'b1;
        misalign  = req_addr[0];
        load_data = ext_half(half_sel, 1'b1);
      end
      FUNC_LHU: begin
        is_load   = 1'b1;
        misalign  = req_addr[0];
        load_data = ext_half(half_sel, 1'b0);
      end
      FUNC_LB: begin
        is_load   = 1'b1;
        load_data = ext_byte(byte_sel, 1'b1);
      end
      FUNC_LBU: begin
        is_load   = 1'b1;
        load_data = ext_byte(byte_sel, 1'b0);
      end
      FUNC_SW: begin
        is_store = 1'b1;
        misalign = |req_addr[1:0];
        byte_en  = 4'b1111;
        wr_lanes = req_wdata;
      end
      FUNC_SH: begin
        is_store = 1'b1;
        misalign = req_addr[0];
        byte_en  = req_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{req_wdata[15:0]}};
      end
      FUNC_SB: begin
        is_store = 1'b1;
        byte_en  = 4'b0001 << req_addr[1:0];
        wr_lanes = {4{req_wdata[7:0]}};
      end
      default: begin
        is_load  = 1'b0;
        is_store = 1'b0;
      end
    endcase
    acc_err_p0   = (is_load | is_store) & (misalign | ~in_range);
    acc_rdata_p0 = (is_load & ~acc_err_p0) ? load_data : '0;
  end

  // NOP and undefined codes fall through the decoder with no access at all
  assign wr_en_p0 = req_valid & req_ready & ~rst & is_store & ~acc_err_p0 & (req_func != FUNC_NOP);

  // Memory array: stores commit on the accept edge, contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[mem_idx][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  // ---- stage p1: request accepted, result held until the core takes it ----
  // Control FSM: accept in IDLE, count out the latency in BUSY, present in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rsp_rdata <= acc_rdata_p0;
            rsp_err   <= acc_err_p0;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            state     <= RESP;
            cnt       <= 4'd0;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the data memory array.
REQ-002 The module SHALL have parameter LATENCY, default 2, legal range 1..15, meaning the cycles from request acceptance to first rsp_valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  core asserts a load/store request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_func  input  4  load_store_func_code from CORE_PKG (NOP, LW, LH, LB, LHU, LBU, SW, SH, SB).
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  core accepts response.
REQ-012 rsp_rdata  output  32  load result, extended per func; 0 for stores, NOP and errors.
REQ-013 rsp_err  output  1  misaligned or out-of-range access.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-015 In IDLE, req_ready SHALL be 1; in BUSY and RESP, it SHALL be 0.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; addr, func, wdata and the computed read data and error SHALL be latched on that edge.
REQ-017 On acceptance, the FSM SHALL go to RESP if LATENCY=1, else to BUSY with a down-counter loaded with LATENCY-1.
REQ-018 In BUSY, the counter SHALL decrement each cycle; the FSM SHALL move to RESP on the edge where the counter is 1, so rsp_valid rises exactly LATENCY cycles after the accept edge.
REQ-019 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until rsp_ready=1; on that edge, the FSM SHALL return to IDLE.
REQ-020 A new request SHALL NOT be accepted on the same edge as a response handshake; back-to-back throughput is one request per LATENCY+1 cycles minimum.
REQ-021 Error conditions SHALL be: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0; or word index addr[31:2] >= DEPTH_WORDS.
REQ-022 On error, there SHALL be no memory write, and the response SHALL have rsp_err=1 and rsp_rdata=0.
REQ-023 For func NOP or an undefined code, there SHALL be no memory access, and the response SHALL have rsp_err=0 and rsp_rdata=0.
REQ-024 Stores SHALL write memory on the accept edge: SB writes lane addr[1:0] from wdata[7:0]; SH writes lanes {addr[1],1}:{addr[1],0} from wdata[15:0]; SW writes all four lanes. Other lanes SHALL be unchanged.
REQ-025 Loads SHALL read the word as it is before any same-edge write.
- LB/LBU: select byte addr[1:0].
- LH/LHU: select half addr[1].
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: full word.
REQ-026 Byte order SHALL be little-endian (lane 0 = bits [7:0]).
REQ-027 Since requests are serialized, a load accepted after a store SHALL observe that store.

Reset
REQ-028 When rst is asserted, the outputs SHALL take these values immediately: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and req_ready=1.
REQ-029 Reset asserted during BUSY or RESP SHALL abort the response without emitting rsp_valid; a store already accepted SHALL remain committed.
REQ-030 Memory contents SHALL NOT be reset.

Verification
REQ-031 With LATENCY=2: SW addr 0x10, wdata 0xDEADBEEF, then LW 0x10 -> rsp_valid exactly 2 cycles after each accept, LW rdata=0xDEADBEEF, err=0.
REQ-032 After REQ-031: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-033 After REQ-031: SB 0x11, wdata 0x55 then LW 0x10 -> 0xDEAD55EF; SH 0x12, wdata 0x1234 then LW 0x10 -> 0x123455EF.
REQ-034 Errors:
- LW 0x12 -> err=1, rdata=0.
- SH 0x11 -> err=1, and a following LW 0x10 returns the unchanged word.
- LW 0x1000 with DEPTH_WORDS=1024 -> err=1.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data held stable, req_ready=0 throughout; then rsp_ready=1 -> IDLE and req_ready=1 next cycle.
REQ-036 Assert rst one cycle after a LW accept -> rsp_valid never rises, req_ready=1 immediately; SW issued before reset remains readable afterward.
